// File: rtl/rgb_to_grey_stream_pkg.sv
// Shared constants for the streaming RGB-to-grey converter: default sizes,
// channel weights, rounding constants and mode encodings.
package rgb_to_grey_stream_pkg;

  localparam int PIXEL_WIDTH_DEF  = 8;
  localparam int TOTAL_PIXELS_DEF = 65536;

  localparam int W601_R = 77;
  localparam int W601_G = 150;
  localparam int W601_B = 29;
  localparam int WAVG_R = 85;
  localparam int WAVG_G = 86;
  localparam int WAVG_B = 85;

  localparam int ROUND_HALF = 128;
  localparam int SHIFT      = 8;

  typedef enum logic [1:0] {
    MODE_LUMA = 2'd0,
    MODE_AVG  = 2'd1,
    MODE_MAX  = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

endpackage

// File: rtl/rgb_to_grey_stream_if.sv
// Pixel stream bus: RGB input beat with mode, grey output beat with frame markers.
interface rgb_to_grey_stream_if #(
  parameter int PIXEL_WIDTH = 8,
  parameter int CNT_W       = 16
);
  logic                   in_valid_i;
  logic                   in_ready_o;
  logic [PIXEL_WIDTH-1:0] r_i;
  logic [PIXEL_WIDTH-1:0] g_i;
  logic [PIXEL_WIDTH-1:0] b_i;
  logic [1:0]             mode_i;
  logic                   out_valid_o;
  logic                   out_ready_i;
  logic [PIXEL_WIDTH-1:0] grey_o;
  logic                   eof_o;
  logic [CNT_W-1:0]       pix_cnt_o;
  logic [15:0]            frame_cnt_o;

  modport slave (
    input  in_valid_i, r_i, g_i, b_i, mode_i, out_ready_i,
    output in_ready_o, out_valid_o, grey_o, eof_o, pix_cnt_o, frame_cnt_o
  );

  modport master (
    output in_valid_i, r_i, g_i, b_i, mode_i, out_ready_i,
    input  in_ready_o, out_valid_o, grey_o, eof_o, pix_cnt_o, frame_cnt_o
  );
endinterface

// File: rtl/rgb_to_grey_stream_grey_weight_calc.sv
// Combinational arithmetic for the converter: weighted products / channel max
// (feeds S2), and round + saturate of the product sum (feeds S3).
module grey_weight_calc
  import rgb_to_grey_stream_pkg::*;
#(
  parameter int PIXEL_WIDTH = PIXEL_WIDTH_DEF
) (
  input  logic [PIXEL_WIDTH-1:0]        r_i,
  input  logic [PIXEL_WIDTH-1:0]        g_i,
  input  logic [PIXEL_WIDTH-1:0]        b_i,
  input  logic [1:0]                    mode_i,
  output logic [2:0][PIXEL_WIDTH+7:0]   prod_o,
  output logic [PIXEL_WIDTH-1:0]        max_o,
  output logic                          is_max_o,
  input  logic [2:0][PIXEL_WIDTH+7:0]   prod_i,
  input  logic [PIXEL_WIDTH-1:0]        max_i,
  input  logic                          is_max_i,
  output logic [PIXEL_WIDTH-1:0]        grey_o
);
  localparam int PW    = PIXEL_WIDTH;
  localparam int PRODW = PW + 8;
  localparam int SUMW  = PW + 10;
  localparam logic [SUMW-1:0] MAXV = SUMW'((1 << PW) - 1);

  logic [2:0][7:0]   w;
  logic [SUMW-1:0]   sum;
  logic [SUMW-1:0]   shifted;

  // Reserved mode falls through to luma weights.
  always_comb begin
    w = {8'(W601_B), 8'(W601_G), 8'(W601_R)};
    if (mode_e'(mode_i) == MODE_AVG) w = {8'(WAVG_B), 8'(WAVG_G), 8'(WAVG_R)};
    prod_o[0] = PRODW'(r_i) * PRODW'(w[0]);
    prod_o[1] = PRODW'(g_i) * PRODW'(w[1]);
    prod_o[2] = PRODW'(b_i) * PRODW'(w[2]);
    max_o = r_i;
    if (g_i > max_o) max_o = g_i;
    if (b_i > max_o) max_o = b_i;
    is_max_o = (mode_e'(mode_i) == MODE_MAX);
  end

  always_comb begin
    sum     = SUMW'(prod_i[0]) + SUMW'(prod_i[1]) + SUMW'(prod_i[2]) + SUMW'(ROUND_HALF);
    shifted = sum >> SHIFT;
    if (is_max_i)             grey_o = max_i;
    else if (shifted > MAXV)  grey_o = '1;
    else                      grey_o = shifted[PW-1:0];
  end

endmodule

// File: rtl/rgb_to_grey_stream.sv
// Three-stage RGB-to-grey stream with global-enable backpressure and an
// output pixel/frame counter that flags the last pixel of each frame.
module rgb_to_grey_stream
  import rgb_to_grey_stream_pkg::*;
#(
  parameter int PIXEL_WIDTH  = PIXEL_WIDTH_DEF,
  parameter int TOTAL_PIXELS = TOTAL_PIXELS_DEF,
  parameter int CNT_W        = (TOTAL_PIXELS > 1) ? $clog2(TOTAL_PIXELS) : 1
) (
  input logic                 clk,
  input logic                 rst,
  rgb_to_grey_stream_if.slave s
);
  localparam int STAGES = 3;
  localparam int PW     = PIXEL_WIDTH;
  localparam int PRODW  = PW + 8;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL_PIXELS - 1);

  logic                  en;
  logic [STAGES:1]       vld_pipe_q, vld_pipe_d;
  logic [PW-1:0]         r_q, r_d, g_q, g_d, b_q, b_d;
  logic [1:0]            mode_q, mode_d;
  logic [2:0][PRODW-1:0] prod_q, prod_d, prod_c;
  logic [PW-1:0]         max_q, max_d, max_c;
  logic                  is_max_q, is_max_d, is_max_c;
  logic [PW-1:0]         grey_q, grey_d, grey_c;
  logic [CNT_W-1:0]      pix_cnt_q, pix_cnt_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;

  grey_weight_calc #(.PIXEL_WIDTH(PW)) u_calc (
    .r_i      (r_q),
    .g_i      (g_q),
    .b_i      (b_q),
    .mode_i   (mode_q),
    .prod_o   (prod_c),
    .max_o    (max_c),
    .is_max_o (is_max_c),
    .prod_i   (prod_q),
    .max_i    (max_q),
    .is_max_i (is_max_q),
    .grey_o   (grey_c)
  );

  // One enable stalls the whole pipe; S3 refills in the cycle it drains.
  always_comb begin
    en          = ~vld_pipe_q[STAGES] | s.out_ready_i;
    vld_pipe_d  = vld_pipe_q;
    r_d         = r_q;
    g_d         = g_q;
    b_d         = b_q;
    mode_d      = mode_q;
    prod_d      = prod_q;
    max_d       = max_q;
    is_max_d    = is_max_q;
    grey_d      = grey_q;
    pix_cnt_d   = pix_cnt_q;
    frame_cnt_d = frame_cnt_q;
    if (en) begin
      vld_pipe_d = {vld_pipe_q[STAGES-1:1], s.in_valid_i};
      r_d        = s.r_i;
      g_d        = s.g_i;
      b_d        = s.b_i;
      mode_d     = s.mode_i;
      prod_d     = prod_c;
      max_d      = max_c;
      is_max_d   = is_max_c;
      grey_d     = grey_c;
    end
    if (vld_pipe_q[STAGES] && s.out_ready_i) begin
      if (pix_cnt_q == LAST) begin
        pix_cnt_d   = '0;
        frame_cnt_d = frame_cnt_q + 16'd1;
      end else begin
        pix_cnt_d   = pix_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q  <= '0;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
      mode_q      <= '0;
      prod_q      <= '0;
      max_q       <= '0;
      is_max_q    <= 1'b0;
      grey_q      <= '0;
      pix_cnt_q   <= '0;
      frame_cnt_q <= '0;
    end else begin
      vld_pipe_q  <= vld_pipe_d;
      r_q         <= r_d;
      g_q         <= g_d;
      b_q         <= b_d;
      mode_q      <= mode_d;
      prod_q      <= prod_d;
      max_q       <= max_d;
      is_max_q    <= is_max_d;
      grey_q      <= grey_d;
      pix_cnt_q   <= pix_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign s.in_ready_o  = en;
  assign s.out_valid_o = vld_pipe_q[STAGES];
  assign s.grey_o      = grey_q;
  assign s.eof_o       = vld_pipe_q[STAGES] & (pix_cnt_q == LAST);
  assign s.pix_cnt_o   = pix_cnt_q;
  assign s.frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_rgb_to_grey_stream.sv
// Scoreboard bench for rgb_to_grey_stream with a 4-pixel frame so wrap/eof
// behaviour is exercised throughout every scenario.
module tb_rgb_to_grey_stream;
  localparam int TP = 4;

  typedef struct packed {
    logic [7:0]  grey;
    logic [1:0]  pix;
    logic        eof;
    logic [15:0] frame;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rgb_to_grey_stream_if #(.PIXEL_WIDTH(8), .CNT_W(2)) bus ();

  rgb_to_grey_stream #(.PIXEL_WIDTH(8), .TOTAL_PIXELS(TP), .CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .s   (bus)
  );

  beat_t exp_q[$];
  beat_t obs_q[$];
  int    acc_cyc[$];
  int    obs_cyc[$];
  int    cyc = 0;
  int    push_cnt = 0;
  int    vectors = 0;
  int    miscompares = 0;

  function automatic logic [7:0] ref_grey(logic [7:0] r, logic [7:0] g, logic [7:0] b, logic [1:0] m);
    int s;
    if (m == 2'd2) begin
      s = r;
      if (g > s) s = g;
      if (b > s) s = b;
      return 8'(s);
    end
    if (m == 2'd1) s = 85 * r + 86 * g + 85 * b;
    else           s = 77 * r + 150 * g + 29 * b;
    s = (s + 128) / 256;
    if (s > 255) s = 255;
    return 8'(s);
  endfunction

  // One clock: drive at posedge+1, record handshakes at negedge.
  task automatic cycle(input logic iv, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                       input logic [1:0] m, input logic ordy,
                       output logic rdy, output logic vld, output logic [7:0] gr);
    bus.in_valid_i  = iv;
    bus.r_i         = r;
    bus.g_i         = g;
    bus.b_i         = b;
    bus.mode_i      = m;
    bus.out_ready_i = ordy;
    @(negedge clk);
    rdy = bus.in_ready_o;
    vld = bus.out_valid_o;
    gr  = bus.grey_o;
    if (!rst) begin
      if (iv && rdy) begin
        exp_q.push_back('{grey: ref_grey(r, g, b, m), pix: 2'(push_cnt % TP),
                          eof: (push_cnt % TP) == TP - 1, frame: 16'(push_cnt / TP)});
        acc_cyc.push_back(cyc);
        push_cnt++;
      end
      if (vld && ordy) begin
        obs_q.push_back('{grey: bus.grey_o, pix: bus.pix_cnt_o, eof: bus.eof_o, frame: bus.frame_cnt_o});
        obs_cyc.push_back(cyc);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    logic rdy, vld;
    logic [7:0] gr;
    for (int i = 0; i < 100 && obs_q.size() < exp_q.size(); i++)
      cycle(1'b0, 8'd0, 8'd0, 8'd0, 2'd0, 1'b1, rdy, vld, gr);
  endtask

  task automatic clear_sb();
    exp_q.delete(); obs_q.delete(); acc_cyc.delete(); obs_cyc.delete();
  endtask

  task automatic do_reset();
    logic rdy, vld;
    logic [7:0] gr;
    rst = 1'b1;
    cycle(1'b0, 8'd0, 8'd0, 8'd0, 2'd0, 1'b1, rdy, vld, gr);
    rst = 1'b0;
    clear_sb();
    push_cnt = 0;
  endtask

  task automatic test_reset();
    bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b0;
    bus.r_i = '0; bus.g_i = '0; bus.b_i = '0; bus.mode_i = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    vectors++; if (bus.out_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid_o); end
    vectors++; if (bus.grey_o !== 8'd0) begin miscompares++; $display("FAIL reset_grey got %0d want 0", bus.grey_o); end
    vectors++; if (bus.eof_o !== 1'b0) begin miscompares++; $display("FAIL reset_eof got %b want 0", bus.eof_o); end
    vectors++; if (bus.pix_cnt_o !== 2'd0) begin miscompares++; $display("FAIL reset_pix_cnt got %0d want 0", bus.pix_cnt_o); end
    vectors++; if (bus.frame_cnt_o !== 16'd0) begin miscompares++; $display("FAIL reset_frame_cnt got %0d want 0", bus.frame_cnt_o); end
    vectors++; if (bus.in_ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready_o); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_luma();
    logic rdy, vld;
    logic [7:0] gr;
    logic [7:0] rv[4] = '{8'd255, 8'd0, 8'd0, 8'd255};
    logic [7:0] gv[4] = '{8'd0, 8'd255, 8'd0, 8'd255};
    logic [7:0] bv[4] = '{8'd0, 8'd0, 8'd255, 8'd255};
    logic [7:0] want[4] = '{8'd77, 8'd149, 8'd29, 8'd255};
    for (int i = 0; i < 4; i++) cycle(1'b1, rv[i], gv[i], bv[i], 2'd0, 1'b1, rdy, vld, gr);
    drain();
    vectors++;
    if (obs_q.size() != 4 || acc_cyc.size() != 4) begin
      miscompares++; $display("FAIL luma_count got %0d want 4", obs_q.size());
    end else begin
      vectors++;
      if (obs_cyc[0] - acc_cyc[0] != 3) begin miscompares++; $display("FAIL luma_latency got %0d want 3", obs_cyc[0] - acc_cyc[0]); end
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (obs_q[i].grey !== want[i] || obs_q[i] !== exp_q[i] || obs_cyc[i] != obs_cyc[0] + i) begin
          miscompares++;
          $display("FAIL luma_%0d got grey %0d pix %0d eof %b cyc %0d want grey %0d pix %0d eof %b cyc %0d",
                   i, obs_q[i].grey, obs_q[i].pix, obs_q[i].eof, obs_cyc[i], want[i], exp_q[i].pix, exp_q[i].eof, obs_cyc[0] + i);
        end
      end
    end
    clear_sb();
  endtask

  task automatic test_modes();
    logic rdy, vld;
    logic [7:0] gr;
    logic [7:0] want[3] = '{8'd60, 8'd90, 8'd54};
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'd30, 8'd60, 8'd90, 2'(i + 1), 1'b1, rdy, vld, gr);
    for (int i = 0; i < 8; i++)
      cycle(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 2'(i % 4), 1'b1, rdy, vld, gr);
    drain();
    vectors++;
    if (obs_q.size() != exp_q.size() || exp_q.size() != 11) begin
      miscompares++; $display("FAIL modes_count got %0d want 11", obs_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (obs_q[i].grey !== want[i]) begin miscompares++; $display("FAIL modes_const_%0d got %0d want %0d", i, obs_q[i].grey, want[i]); end
      end
      for (int i = 0; i < 11; i++) begin
        vectors++;
        if (obs_q[i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL modes_%0d got grey %0d pix %0d eof %b frame %0d want grey %0d pix %0d eof %b frame %0d",
                   i, obs_q[i].grey, obs_q[i].pix, obs_q[i].eof, obs_q[i].frame, exp_q[i].grey, exp_q[i].pix, exp_q[i].eof, exp_q[i].frame);
        end
      end
    end
    clear_sb();
  endtask

  task automatic test_backpressure();
    logic rdy, vld, ordy;
    logic [7:0] gr, prev_gr;
    int sent = 0;
    prev_gr = '0;
    for (int c = 0; c < 60 && sent < 10; c++) begin
      ordy = !(c >= 4 && c <= 8);
      cycle(1'b1, 8'(sent * 23), 8'(255 - sent * 17), 8'(sent * 11 + 5), 2'(sent % 4), ordy, rdy, vld, gr);
      if (rdy) sent++;
      if (c >= 4 && c <= 8) begin
        vectors++;
        if (rdy !== 1'b0 || vld !== 1'b1) begin miscompares++; $display("FAIL bp_hold_c%0d got in_ready %b out_valid %b want 0 1", c, rdy, vld); end
        if (c > 4) begin
          vectors++;
          if (gr !== prev_gr) begin miscompares++; $display("FAIL bp_stable_c%0d got %0d want %0d", c, gr, prev_gr); end
        end
      end
      prev_gr = gr;
    end
    drain();
    vectors++;
    if (obs_q.size() != exp_q.size() || exp_q.size() != 10) begin
      miscompares++; $display("FAIL bp_count got %0d want 10", obs_q.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        vectors++;
        if (obs_q[i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL bp_%0d got grey %0d pix %0d eof %b want grey %0d pix %0d eof %b",
                   i, obs_q[i].grey, obs_q[i].pix, obs_q[i].eof, exp_q[i].grey, exp_q[i].pix, exp_q[i].eof);
        end
      end
    end
    clear_sb();
  endtask

  task automatic test_frame_wrap();
    logic rdy, vld;
    logic [7:0] gr;
    do_reset();
    for (int i = 0; i < 9; i++) cycle(1'b1, 8'(i * 29), 8'(i * 7), 8'(200 - i), 2'd0, 1'b1, rdy, vld, gr);
    drain();
    vectors++;
    if (obs_q.size() != 9) begin
      miscompares++; $display("FAIL wrap_count got %0d want 9", obs_q.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        vectors++;
        if (obs_q[i].pix !== 2'(i % 4) || obs_q[i].eof !== (i == 3 || i == 7) || obs_q[i].grey !== exp_q[i].grey) begin
          miscompares++;
          $display("FAIL wrap_%0d got pix %0d eof %b grey %0d want pix %0d eof %b grey %0d",
                   i, obs_q[i].pix, obs_q[i].eof, obs_q[i].grey, i % 4, (i == 3 || i == 7), exp_q[i].grey);
        end
      end
    end
    vectors++;
    if (bus.frame_cnt_o !== 16'd2) begin miscompares++; $display("FAIL wrap_frames got %0d want 2", bus.frame_cnt_o); end
    clear_sb();
  endtask

  task automatic test_reset_flush();
    logic rdy, vld;
    logic [7:0] gr;
    for (int i = 0; i < 2; i++) cycle(1'b1, 8'd10, 8'd20, 8'd30, 2'd1, 1'b1, rdy, vld, gr);
    do_reset();
    vectors++;
    if (bus.out_valid_o !== 1'b0 || bus.pix_cnt_o !== 2'd0 || bus.frame_cnt_o !== 16'd0) begin
      miscompares++;
      $display("FAIL flush_state got valid %b pix %0d frame %0d want 0 0 0", bus.out_valid_o, bus.pix_cnt_o, bus.frame_cnt_o);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 8'd0, 8'd0, 8'd0, 2'd0, 1'b1, rdy, vld, gr);
      vectors++;
      if (vld !== 1'b0) begin miscompares++; $display("FAIL flush_ghost_%0d got out_valid %b want 0", i, vld); end
    end
    cycle(1'b1, 8'd100, 8'd50, 8'd200, 2'd2, 1'b1, rdy, vld, gr);
    drain();
    vectors++;
    if (obs_q.size() != 1) begin
      miscompares++; $display("FAIL flush_count got %0d want 1", obs_q.size());
    end else if (obs_q[0].grey !== 8'd200 || obs_q[0].pix !== 2'd0 || obs_cyc[0] - acc_cyc[0] != 3) begin
      miscompares++;
      $display("FAIL flush_beat got grey %0d pix %0d lat %0d want grey 200 pix 0 lat 3", obs_q[0].grey, obs_q[0].pix, obs_cyc[0] - acc_cyc[0]);
    end
    clear_sb();
  endtask

  task automatic test_random();
    logic rdy, vld, iv;
    logic [7:0] gr;
    int sent = 0;
    for (int c = 0; c < 20000 && sent < 1000; c++) begin
      iv = ($urandom_range(0, 9) < 7);
      cycle(iv, 8'($urandom), 8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 9) < 7), rdy, vld, gr);
      if (iv && rdy) sent++;
    end
    drain();
    vectors++;
    if (obs_q.size() != exp_q.size() || exp_q.size() != 1000) begin
      miscompares++; $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < 1000; i++) begin
        vectors++;
        if (obs_q[i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL rand_%0d got grey %0d pix %0d eof %b frame %0d want grey %0d pix %0d eof %b frame %0d",
                   i, obs_q[i].grey, obs_q[i].pix, obs_q[i].eof, obs_q[i].frame, exp_q[i].grey, exp_q[i].pix, exp_q[i].eof, exp_q[i].frame);
        end
      end
    end
    clear_sb();
  endtask

  initial begin
    test_reset();
    test_luma();
    test_modes();
    test_backpressure();
    test_frame_wrap();
    test_reset_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
